// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if
// Groups the stopwatch button inputs and the digit/status outputs.
// The master side (bench or button logic) drives the buttons; the slave
// side (the stopwatch) drives the four BCD digits, running and wrap.
interface bcd_stopwatch_if;
   logic       btn_ss;
   logic       clr;
   logic       lap;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic       running;
   logic       wrap;

   modport master (
      output btn_ss, clr, lap,
      input  d0, d1, d2, d3, running, wrap
   );

   modport slave (
      input  btn_ss, clr, lap,
      output d0, d1, d2, d3, running, wrap
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
// Four-digit BCD stopwatch (M:SS.t, 0:00.0 .. 9:59.9) feeding the per-digit
// 7-segment decoders. The start/stop button toggles run state on its rising
// edge, a prescaler divides clk down to 0.1 s ticks, and the digits cascade
// with a one-cycle wrap pulse on rollover from 9:59.9.
// Optional lap-hold display freeze is enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch #(
   parameter int TICK_DIV = 5000000
) (
   input  logic          clk,
   input  logic          rst_n,
   bcd_stopwatch_if.slave sw
);

   localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_btnQ;
   logic [PRE_W-1:0] r_pre;
   logic [3:0]       r_d0;
   logic [3:0]       r_d1;
   logic [3:0]       r_d2;
   logic [3:0]       r_d3;
   logic             r_wrap;

   logic w_running;
   logic w_ssEdge;
   logic w_tick;
   logic w_d0Carry;
   logic w_d1Carry;
   logic w_d2Carry;
   logic w_d3Carry;

   assign w_running = (r_state == ST_RUNNING);
   assign w_ssEdge  = sw.btn_ss & ~r_btnQ;
   assign w_tick    = w_running & (r_pre == PRE_MAX);
   assign w_d0Carry = (r_d0 == 4'd9);
   assign w_d1Carry = w_d0Carry & (r_d1 == 4'd9);
   assign w_d2Carry = w_d1Carry & (r_d2 == 4'd5);
   assign w_d3Carry = w_d2Carry & (r_d3 == 4'd9);

   // Run/stop state: button rising edge toggles, clear forces stopped; the
   // button history always tracks so a button held through clear won't retrigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STOPPED;
         r_btnQ  <= 1'b0;
      end else begin
         r_btnQ <= sw.btn_ss;
         if (sw.clr) begin
            r_state <= ST_STOPPED;
         end else if (w_ssEdge) begin
            r_state <= (r_state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
         end
      end
   end

   // Prescaler: advances only while running and holds while stopped, so a
   // resume finishes the partial 0.1 s period that was interrupted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (sw.clr) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else if (w_running) begin
         r_pre <= r_pre + 1'b1;
      end
   end

   // Digit cascade: tenths -> seconds units -> seconds tens (0..5) -> minutes,
   // with wrap pulsing for the single cycle after 9:59.9 rolls to 0:00.0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d0   <= 4'd0;
         r_d1   <= 4'd0;
         r_d2   <= 4'd0;
         r_d3   <= 4'd0;
         r_wrap <= 1'b0;
      end else if (sw.clr) begin
         r_d0   <= 4'd0;
         r_d1   <= 4'd0;
         r_d2   <= 4'd0;
         r_d3   <= 4'd0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_tick & w_d3Carry;
         if (w_tick) begin
            r_d0 <= w_d0Carry ? 4'd0 : r_d0 + 4'd1;
            if (w_d0Carry) begin
               r_d1 <= (r_d1 == 4'd9) ? 4'd0 : r_d1 + 4'd1;
            end
            if (w_d1Carry) begin
               r_d2 <= (r_d2 == 4'd5) ? 4'd0 : r_d2 + 4'd1;
            end
            if (w_d2Carry) begin
               r_d3 <= (r_d3 == 4'd9) ? 4'd0 : r_d3 + 4'd1;
            end
         end
      end
   end

`ifdef BCD_STOPWATCH_LAP_EN
   logic       r_lapQ;
   logic       r_lapHold;
   logic [3:0] r_f0;
   logic [3:0] r_f1;
   logic [3:0] r_f2;
   logic [3:0] r_f3;
   logic       w_lapEdge;

   assign w_lapEdge = sw.lap & ~r_lapQ;

   // Lap hold: each lap rising edge toggles hold; entering hold snapshots the
   // live digits so the display freezes while the count keeps going.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lapQ    <= 1'b0;
         r_lapHold <= 1'b0;
         r_f0      <= 4'd0;
         r_f1      <= 4'd0;
         r_f2      <= 4'd0;
         r_f3      <= 4'd0;
      end else begin
         r_lapQ <= sw.lap;
         if (sw.clr) begin
            r_lapHold <= 1'b0;
            r_f0      <= 4'd0;
            r_f1      <= 4'd0;
            r_f2      <= 4'd0;
            r_f3      <= 4'd0;
         end else if (w_lapEdge) begin
            if (!r_lapHold) begin
               r_lapHold <= 1'b1;
               r_f0      <= r_d0;
               r_f1      <= r_d1;
               r_f2      <= r_d2;
               r_f3      <= r_d3;
            end else begin
               r_lapHold <= 1'b0;
            end
         end
      end
   end

   assign sw.d0 = r_lapHold ? r_f0 : r_d0;
   assign sw.d1 = r_lapHold ? r_f1 : r_d1;
   assign sw.d2 = r_lapHold ? r_f2 : r_d2;
   assign sw.d3 = r_lapHold ? r_f3 : r_d3;
`else
   assign sw.d0 = r_d0;
   assign sw.d1 = r_d1;
   assign sw.d2 = r_d2;
   assign sw.d3 = r_d3;
`endif

   assign sw.running = w_running;
   assign sw.wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
// Directed bench for bcd_stopwatch with TICK_DIV=4 (one tick every 4 running
// cycles). Expected digit values are worked out by hand from the tick count.
// The lap section runs only when BCD_STOPWATCH_LAP_EN is defined.
module tb_bcd_stopwatch;

   localparam int TICK_DIV = 4;

   logic clk;
   logic rst_n;
   int   assertCount;
   int   failCount;
   int   wrapCount;

   bcd_stopwatch_if swIf ();

   bcd_stopwatch #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (swIf.slave)
   );

   // 10 ns clock; all driving and sampling happens 1 ns after the rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts every cycle in which the wrap pulse is seen, sampled mid-period.
   always @(negedge clk) begin
      if (rst_n && swIf.wrap === 1'b1) begin
         wrapCount = wrapCount + 1;
      end
   end

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount = assertCount + 1;
      if (actual !== expected) begin
         failCount = failCount + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drives the button levels, then advances the given number of clock edges.
   task automatic applyStimulus(input logic btn, input logic clear, input logic lapBtn,
                                input int cycles);
      swIf.btn_ss = btn;
      swIf.clr    = clear;
      swIf.lap    = lapBtn;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compares the displayed time as a packed M,S,S,t value.
   task automatic checkTime(input string tag, input logic [15:0] expected);
      checkOutput(tag, {16'd0, swIf.d3, swIf.d2, swIf.d1, swIf.d0}, {16'd0, expected});
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      wrapCount   = 0;
      rst_n       = 1'b0;
      swIf.btn_ss = 1'b0;
      swIf.clr    = 1'b0;
      swIf.lap    = 1'b0;
      #12;
      checkTime("reset_digits", 16'h0000);
      checkOutput("reset_running", {31'd0, swIf.running}, 32'd0);
      checkOutput("reset_wrap", {31'd0, swIf.wrap}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle: nothing should move.
      applyStimulus(1'b0, 1'b0, 1'b0, 20);
      checkTime("idle_digits", 16'h0000);
      checkOutput("idle_running", {31'd0, swIf.running}, 32'd0);
      checkOutput("idle_wrap_count", wrapCount, 32'd0);

      // Start: running one cycle after the button edge, held for 40 cycles.
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("start_running", {31'd0, swIf.running}, 32'd1);
      checkTime("start_digits", 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      checkTime("before_first_tick", 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkTime("first_tick", 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b0, 32);
      checkTime("tick9_at36", 16'h0009);
      applyStimulus(1'b0, 1'b0, 1'b0, 4);
      checkTime("carry_at40", 16'h0010);
      checkOutput("still_running", {31'd0, swIf.running}, 32'd1);

      // 0:01.0 -> 0:05.9 is 49 ticks, then one more tick.
      applyStimulus(1'b0, 1'b0, 1'b0, 49 * TICK_DIV);
      checkTime("preload_0_05_9", 16'h0059);
      applyStimulus(1'b0, 1'b0, 1'b0, TICK_DIV);
      checkTime("carry_0_06_0", 16'h0060);

      // 0:06.0 -> 0:59.9 is 539 ticks, then one more tick.
      applyStimulus(1'b0, 1'b0, 1'b0, 539 * TICK_DIV);
      checkTime("preload_0_59_9", 16'h0599);
      applyStimulus(1'b0, 1'b0, 1'b0, TICK_DIV);
      checkTime("carry_1_00_0", 16'h1000);

      // 1:00.0 -> 9:59.9 is 5399 ticks; next tick wraps.
      applyStimulus(1'b0, 1'b0, 1'b0, 5399 * TICK_DIV);
      checkTime("preload_9_59_9", 16'h9599);
      checkOutput("no_wrap_before", {31'd0, swIf.wrap}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, TICK_DIV);
      checkTime("wrap_digits", 16'h0000);
      checkOutput("wrap_pulse", {31'd0, swIf.wrap}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("wrap_one_cycle", {31'd0, swIf.wrap}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, TICK_DIV - 2);
      checkTime("after_wrap_hold", 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkTime("after_wrap_0_00_1", 16'h0001);
      checkOutput("wrap_total", wrapCount, 32'd1);

      // Stop with pre=2: one cycle to pre=1, then the stop edge takes pre to 2.
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("stopped", {31'd0, swIf.running}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 10);
      checkTime("hold_while_stopped", 16'h0001);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("restart_running", {31'd0, swIf.running}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkTime("resume_partial_1", 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkTime("resume_partial_2", 16'h0002);

      // clr in the same cycle as a tick and a start/stop edge.
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      checkTime("pre_clr_digits", 16'h0002);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkTime("clr_digits", 16'h0000);
      checkOutput("clr_running", {31'd0, swIf.running}, 32'd0);
      checkOutput("clr_wrap", {31'd0, swIf.wrap}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5);
      checkOutput("no_retrigger", {31'd0, swIf.running}, 32'd0);
      checkTime("clr_stays_zero", 16'h0000);

      // Start/stop edge coincides with a tick: digit advances, then stops.
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("start2_running", {31'd0, swIf.running}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkTime("edge_tick_digits", 16'h0001);
      checkOutput("edge_tick_stopped", {31'd0, swIf.running}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5);
      checkTime("edge_tick_hold", 16'h0001);

`ifdef BCD_STOPWATCH_LAP_EN
      // Lap: freeze at 0:01.3, live count runs on to 0:02.1, release shows live.
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 13 * TICK_DIV);
      checkTime("lap_live_0_01_3", 16'h0013);
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8 * TICK_DIV - 1);
      checkTime("lap_frozen", 16'h0013);
      checkOutput("lap_running", {31'd0, swIf.running}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      checkTime("lap_release_live", 16'h0021);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
